fb_swap_controller: RTL
=======================

// Module: fb_swap_controller
// PURPOSE
//  Sequencer for the double-buffered 320x180 RGB565 frame buffer pair. Accepts ray-cast
//  pixel writes via valid/ready, optionally clears the back buffer before each frame, and
//  swaps front/back only when ray frame done AND video frame end both seen. Sits between
//  the DDA/flattening pipeline and the two single-port frame BRAMs; drives write port + select.
// PARAMETERS
//  SCREEN_WIDTH   320  pixels per buffer row
//  SCREEN_HEIGHT  180  rows per buffer; DEPTH = SCREEN_WIDTH*SCREEN_HEIGHT (57600)
//  PIXEL_WIDTH    16   RGB565 pixel width
// PORTS
//  pixel_clk_in        in   1   sole clock
//  rst_in              in   1   reset, asynchronous, active-high
//  ray_valid_in        in   1   ray pixel valid
//  ray_ready_out       out  1   controller accepts ray pixel (high only in WRITE)
//  ray_address_in      in   16  flat pixel address, 0..DEPTH-1, any order
//  ray_pixel_in        in   16  RGB565 pixel
//  ray_last_in         in   1   qualifies final pixel of the ray sweep (with handshake)
//  video_last_pixel_in in   1   1-cycle pulse: last active pixel of displayed frame
//  clear_en_in         in   1   clear back buffer to clear_color_in before each frame
//  clear_color_in      in   16  RGB565 clear value
//  wr_en_out           out  1   back-buffer write strobe
//  wr_address_out      out  16  back-buffer write address
//  wr_pixel_out        out  16  back-buffer write data
//  back_sel_out        out  1   0: back=FB1, front=FB2; 1: back=FB2, front=FB1
//  swap_out            out  1   1-cycle pulse, cycle back_sel_out toggles
//  frame_count_out     out  8   completed swaps, wraps 255->0
//  repeat_count_out    out  8   video frames re-shown while waiting on ray, saturates 255
//  addr_err_out        out  1   sticky: out-of-range ray address accepted
// BEHAVIOUR
//  Reset (async): state CLEAR, clear counter 0, all outputs 0, video_done flag 0.
//  States: CLEAR -> WRITE -> WAIT_VIDEO -> SWAP -> CLEAR.
//  CLEAR: if clear_en_in=0 on entry cycle -> WRITE next cycle, no writes. Else writes
//   clear_color_in to addresses 0..DEPTH-1, one per cycle (DEPTH cycles), ->WRITE after DEPTH-1.
//   clear_en_in/clear_color_in sampled each cycle; clear_en_in only checked on entry.
//  WRITE: ray_ready_out=1. Handshake = valid&ready. Write latency 1: cycle after handshake
//   wr_en_out=1 with registered address/pixel. Address >= DEPTH: accepted, wr_en_out stays 0,
//   addr_err_out set (cleared only by reset). Handshake with ray_last_in=1 -> WAIT_VIDEO.
//  WAIT_VIDEO: ray_ready_out=0. -> SWAP when video_done=1 or video_last_pixel_in=1.
//  SWAP (1 cycle): back_sel_out toggles, swap_out=1, frame_count_out+1, video_done<=0.
//  video_done: set by video_last_pixel_in in CLEAR/WRITE; a pulse while video_done already
//   set increments repeat_count_out (sat 255). Pulse coincident with SWAP is dropped.
//  Pulse in CLEAR/WRITE and ray_last same frame in either order -> exactly one swap.
//  wr_en_out never asserted in WAIT_VIDEO/SWAP; front buffer never written.
//  All outputs registered except ray_ready_out (decoded from state register).
// TESTING (SCREEN_WIDTH=4, SCREEN_HEIGHT=2, DEPTH=8 unless noted)
//  Reset mid-CLEAR at addr 5 -> same cycle wr_en_out=0, back_sel_out=0; after release clear restarts at 0.
//  clear_en_in=1, color 16'hF800 -> 8 writes addr 0..7 data F800, then ray_ready_out=1.
//  Write addr 3 pixel 16'h07E0 -> next cycle wr_en_out=1, addr 3, data 07E0; addr 9 -> no write, addr_err_out=1.
//  video pulse in WRITE, then ray_last -> SWAP 1 cycle after WAIT_VIDEO entry: swap_out=1, back_sel_out=1, frame_count_out=1.
//  ray_last first, video pulse 100 cycles later -> swap_out cycle after pulse; no writes in between.
//  3 video pulses during WRITE -> repeat_count_out=2, one swap only after ray_last.

Source files
------------

// File: rtl/fb_swap_controller.sv
// Front/back frame buffer sequencer: optional back-buffer clear, ray pixel writes,
// and a swap once both the ray sweep and the displayed video frame are finished.
//
// state      | meaning
// -----------+-----------------------------------------------------------------
// CLEAR      | optional sweep writing clear_color_in to every back-buffer address
// WRITE      | accepting ray pixels, written to the back buffer one cycle later
// WAIT_VIDEO | ray sweep finished, waiting for the displayed frame to end
// SWAP       | back/front exchanged this cycle, video_done flag dropped
module fb_swap_controller #(
  parameter int SCREEN_WIDTH  = 320,
  parameter int SCREEN_HEIGHT = 180,
  parameter int PIXEL_WIDTH   = 16
) (
  input  logic                   pixel_clk_in,
  input  logic                   rst_in,
  input  logic                   ray_valid_in,
  output logic                   ray_ready_out,
  input  logic [15:0]            ray_address_in,
  input  logic [PIXEL_WIDTH-1:0] ray_pixel_in,
  input  logic                   ray_last_in,
  input  logic                   video_last_pixel_in,
  input  logic                   clear_en_in,
  input  logic [PIXEL_WIDTH-1:0] clear_color_in,
  output logic                   wr_en_out,
  output logic [15:0]            wr_address_out,
  output logic [PIXEL_WIDTH-1:0] wr_pixel_out,
  output logic                   back_sel_out,
  output logic                   swap_out,
  output logic [7:0]             frame_count_out,
  output logic [7:0]             repeat_count_out,
  output logic                   addr_err_out
);

  localparam int          DEPTH     = SCREEN_WIDTH * SCREEN_HEIGHT;
  localparam logic [15:0] LAST_ADDR = 16'(DEPTH - 1);

  typedef enum logic [1:0] {
    S_CLEAR      = 2'd0,
    S_WRITE      = 2'd1,
    S_WAIT_VIDEO = 2'd2,
    S_SWAP       = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [15:0]            clear_cnt_q, clear_cnt_d;
  logic                   video_done_q, video_done_d;
  logic                   wr_en_d;
  logic [15:0]            wr_address_d;
  logic [PIXEL_WIDTH-1:0] wr_pixel_d;
  logic                   back_sel_d;
  logic                   swap_d;
  logic [7:0]             frame_count_d;
  logic [7:0]             repeat_count_d;
  logic                   addr_err_d;
  logic                   handshake;

  assign ray_ready_out = (state_q == S_WRITE);
  assign handshake     = ray_valid_in & ray_ready_out;

  always_comb begin
    state_d        = state_q;
    clear_cnt_d    = clear_cnt_q;
    video_done_d   = video_done_q;
    wr_en_d        = 1'b0;
    wr_address_d   = wr_address_out;
    wr_pixel_d     = wr_pixel_out;
    back_sel_d     = back_sel_out;
    swap_d         = 1'b0;
    frame_count_d  = frame_count_out;
    repeat_count_d = repeat_count_out;
    addr_err_d     = addr_err_out;

    // End-of-video pulses only count while the next frame is still being built.
    if (video_last_pixel_in && (state_q == S_CLEAR || state_q == S_WRITE)) begin
      if (video_done_q) begin
        if (repeat_count_out != 8'hFF) repeat_count_d = repeat_count_out + 8'd1;
      end else begin
        video_done_d = 1'b1;
      end
    end

    case (state_q)
      S_CLEAR: begin
        // clear_cnt_q == 0 marks the entry cycle, the only time clear_en_in is looked at.
        if (clear_cnt_q == 16'd0 && !clear_en_in) begin
          state_d = S_WRITE;
        end else begin
          wr_en_d      = 1'b1;
          wr_address_d = clear_cnt_q;
          wr_pixel_d   = clear_color_in;
          if (clear_cnt_q == LAST_ADDR) begin
            clear_cnt_d = 16'd0;
            state_d     = S_WRITE;
          end else begin
            clear_cnt_d = clear_cnt_q + 16'd1;
          end
        end
      end
      S_WRITE: begin
        if (handshake) begin
          wr_address_d = ray_address_in;
          wr_pixel_d   = ray_pixel_in;
          if (ray_address_in <= LAST_ADDR) wr_en_d = 1'b1;
          else addr_err_d = 1'b1;
          if (ray_last_in) state_d = S_WAIT_VIDEO;
        end
      end
      S_WAIT_VIDEO: begin
        // Swap outputs are registered on entry so swap_out is high during SWAP itself.
        if (video_done_q || video_last_pixel_in) begin
          state_d       = S_SWAP;
          swap_d        = 1'b1;
          back_sel_d    = ~back_sel_out;
          frame_count_d = frame_count_out + 8'd1;
        end
      end
      S_SWAP: begin
        state_d      = S_CLEAR;
        video_done_d = 1'b0;
      end
      default: state_d = S_CLEAR;
    endcase
  end

  always_ff @(posedge pixel_clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q          <= S_CLEAR;
      clear_cnt_q      <= 16'd0;
      video_done_q     <= 1'b0;
      wr_en_out        <= 1'b0;
      wr_address_out   <= 16'd0;
      wr_pixel_out     <= '0;
      back_sel_out     <= 1'b0;
      swap_out         <= 1'b0;
      frame_count_out  <= 8'd0;
      repeat_count_out <= 8'd0;
      addr_err_out     <= 1'b0;
    end else begin
      state_q          <= state_d;
      clear_cnt_q      <= clear_cnt_d;
      video_done_q     <= video_done_d;
      wr_en_out        <= wr_en_d;
      wr_address_out   <= wr_address_d;
      wr_pixel_out     <= wr_pixel_d;
      back_sel_out     <= back_sel_d;
      swap_out         <= swap_d;
      frame_count_out  <= frame_count_d;
      repeat_count_out <= repeat_count_d;
      addr_err_out     <= addr_err_d;
    end
  end

endmodule
